// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared pipeline definitions for the hazard/stall sequencer and the datapath:
//   - hazard sequencer state encoding
//   - canonical NOP instruction word (addi x0, x0, 0)
//   - index of the hard-wired zero register
// ---------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALTED   = 2'd2
  } hazard_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [4:0]  REG_X0    = 5'd0;

endpackage : pipe_hazard_ctrl_pkg

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   i_clk    core clock
//   i_clear  synchronous clear (takes priority over i_inc)
//   i_inc    add one this cycle unless already saturated
//   o_count  current count
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      o_count <= '0;
    end else if (i_inc && (o_count != {CNT_W{1'b1}})) begin
      o_count <= o_count + 1'b1;
    end
  end

endmodule : sat_counter

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush sequencer for the five-stage pipeline registers.
// Resolves load-use hazards, EX-stage redirects, multi-cycle data-memory
// accesses and halt retirement into per-register hold/flush controls, and
// keeps saturating performance counters.
// Ports:
//   i_clk, i_rst                clock, synchronous active-high reset
//   i_id_rs1/rs2_addr/_used     source operands of the instruction in ID
//   i_ex_valid/mem_read/rd_addr EX instruction validity, load flag, dest reg
//   i_ex_redirect               EX resolved a taken branch/jump
//   i_mem_valid/i_mem_access    EX/MEM holds a valid load/store
//   i_dmem_ready                data memory completes the access this cycle
//   i_wb_retire_halt            halt instruction retiring in WB
//   o_pc_stall .. o_ex_mem_stall  register holds
//   o_if_id_flush/o_id_ex_flush   bubble/NOP injection into IF/ID, ID/EX
//   o_mem_wb_bubble             bubble into MEM/WB
//   o_dmem_req                  data memory request strobe
//   o_halted                    core halted (registered)
//   o_stall_cycles/o_flush_count saturating performance counters
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       i_id_rs1_addr,
  input  logic [4:0]       i_id_rs2_addr,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic             i_ex_valid,
  input  logic             i_ex_mem_read,
  input  logic [4:0]       i_ex_rd_addr,
  input  logic             i_ex_redirect,
  input  logic             i_mem_valid,
  input  logic             i_mem_access,
  input  logic             i_dmem_ready,
  input  logic             i_wb_retire_halt,
  output logic             o_pc_stall,
  output logic             o_if_id_stall,
  output logic             o_if_id_flush,
  output logic             o_id_ex_stall,
  output logic             o_id_ex_flush,
  output logic             o_ex_mem_stall,
  output logic             o_mem_wb_bubble,
  output logic             o_dmem_req,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_count
);

  hazard_state_e state, state_nxt;
  logic          load_use;
  logic          mem_op;
  logic          redirect_taken;
  logic          stall_any;

  // A load writing x0 never creates a dependency.
  assign load_use = i_ex_valid && i_ex_mem_read && (i_ex_rd_addr != REG_X0) &&
                    ((i_id_rs1_used && (i_id_rs1_addr == i_ex_rd_addr)) ||
                     (i_id_rs2_used && (i_id_rs2_addr == i_ex_rd_addr)));

  assign mem_op = i_mem_valid && i_mem_access;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt       = state;
    o_pc_stall      = 1'b0;
    o_if_id_stall   = 1'b0;
    o_if_id_flush   = 1'b0;
    o_id_ex_stall   = 1'b0;
    o_id_ex_flush   = 1'b0;
    o_ex_mem_stall  = 1'b0;
    o_mem_wb_bubble = 1'b0;
    o_dmem_req      = 1'b0;
    redirect_taken  = 1'b0;

    if (i_rst) begin
      // Drain the front of the pipe while reset is held.
      o_if_id_flush   = 1'b1;
      o_id_ex_flush   = 1'b1;
      o_mem_wb_bubble = 1'b1;
      state_nxt       = ST_RUN;
    end else begin
      unique case (state)
        ST_RUN: begin
          o_dmem_req = mem_op;
          if (mem_op && !i_dmem_ready) begin
            o_pc_stall      = 1'b1;
            o_if_id_stall   = 1'b1;
            o_id_ex_stall   = 1'b1;
            o_ex_mem_stall  = 1'b1;
            o_mem_wb_bubble = 1'b1;
            state_nxt       = ST_MEM_WAIT;
          end else if (i_ex_redirect && i_ex_valid) begin
            // Wins over load-use: the dependent instruction is flushed anyway.
            o_if_id_flush  = 1'b1;
            o_id_ex_flush  = 1'b1;
            redirect_taken = 1'b1;
          end else if (load_use) begin
            o_pc_stall    = 1'b1;
            o_if_id_stall = 1'b1;
            o_id_ex_flush = 1'b1;
          end
        end

        ST_MEM_WAIT: begin
          o_dmem_req = 1'b1;
          if (!i_dmem_ready) begin
            o_pc_stall      = 1'b1;
            o_if_id_stall   = 1'b1;
            o_id_ex_stall   = 1'b1;
            o_ex_mem_stall  = 1'b1;
            o_mem_wb_bubble = 1'b1;
          end else begin
            // A redirect held in the frozen EX is taken on the next RUN cycle.
            state_nxt = ST_RUN;
          end
        end

        ST_HALTED: begin
          o_pc_stall      = 1'b1;
          o_if_id_stall   = 1'b1;
          o_id_ex_stall   = 1'b1;
          o_ex_mem_stall  = 1'b1;
          o_mem_wb_bubble = 1'b1;
        end

        default: begin
          state_nxt = ST_RUN;
        end
      endcase

      // Halt retirement outranks everything, including an outstanding access.
      if (i_wb_retire_halt) begin
        state_nxt = ST_HALTED;
      end
    end
  end

  assign o_halted  = (state == ST_HALTED);
  assign stall_any = !i_rst && (o_pc_stall || o_ex_mem_stall) && (state != ST_HALTED);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .i_clk   (i_clk),
    .i_clear (i_rst),
    .i_inc   (stall_any),
    .o_count (o_stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .i_clk   (i_clk),
    .i_clear (i_rst),
    .i_inc   (redirect_taken),
    .o_count (o_flush_count)
  );

endmodule : pipe_hazard_ctrl

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl. Counters are built 4 bits wide so that
// saturation is reachable in a short run. Inputs are driven 1 time unit after
// a rising edge; combinational outputs are checked 1 unit after that, and
// registered values 1 unit after the edge.
// Control vector order: {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
//                        id_ex_flush, ex_mem_stall, mem_wb_bubble, dmem_req,
//                        halted}
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;

  localparam logic [8:0] CTL_IDLE   = 9'b000000000;
  localparam logic [8:0] CTL_RST    = 9'b001010100;
  localparam logic [8:0] CTL_RST_H  = 9'b001010101;
  localparam logic [8:0] CTL_LU     = 9'b110010000;
  localparam logic [8:0] CTL_REQ    = 9'b000000010;
  localparam logic [8:0] CTL_MSTALL = 9'b110101110;
  localparam logic [8:0] CTL_REDIR  = 9'b001010000;
  localparam logic [8:0] CTL_HALT   = 9'b110101101;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic [4:0]       i_id_rs1_addr, i_id_rs2_addr, i_ex_rd_addr;
  logic             i_id_rs1_used, i_id_rs2_used;
  logic             i_ex_valid, i_ex_mem_read, i_ex_redirect;
  logic             i_mem_valid, i_mem_access, i_dmem_ready;
  logic             i_wb_retire_halt;
  logic             o_pc_stall, o_if_id_stall, o_if_id_flush;
  logic             o_id_ex_stall, o_id_ex_flush, o_ex_mem_stall;
  logic             o_mem_wb_bubble, o_dmem_req, o_halted;
  logic [CNT_W-1:0] o_stall_cycles, o_flush_count;
  logic [8:0]       ctl;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  assign ctl = {o_pc_stall, o_if_id_stall, o_if_id_flush, o_id_ex_stall,
                o_id_ex_flush, o_ex_mem_stall, o_mem_wb_bubble, o_dmem_req,
                o_halted};

  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_id_rs1_addr    (i_id_rs1_addr),
    .i_id_rs2_addr    (i_id_rs2_addr),
    .i_id_rs1_used    (i_id_rs1_used),
    .i_id_rs2_used    (i_id_rs2_used),
    .i_ex_valid       (i_ex_valid),
    .i_ex_mem_read    (i_ex_mem_read),
    .i_ex_rd_addr     (i_ex_rd_addr),
    .i_ex_redirect    (i_ex_redirect),
    .i_mem_valid      (i_mem_valid),
    .i_mem_access     (i_mem_access),
    .i_dmem_ready     (i_dmem_ready),
    .i_wb_retire_halt (i_wb_retire_halt),
    .o_pc_stall       (o_pc_stall),
    .o_if_id_stall    (o_if_id_stall),
    .o_if_id_flush    (o_if_id_flush),
    .o_id_ex_stall    (o_id_ex_stall),
    .o_id_ex_flush    (o_id_ex_flush),
    .o_ex_mem_stall   (o_ex_mem_stall),
    .o_mem_wb_bubble  (o_mem_wb_bubble),
    .o_dmem_req       (o_dmem_req),
    .o_halted         (o_halted),
    .o_stall_cycles   (o_stall_cycles),
    .o_flush_count    (o_flush_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    i_id_rs1_addr    = 5'd0;
    i_id_rs2_addr    = 5'd0;
    i_id_rs1_used    = 1'b0;
    i_id_rs2_used    = 1'b0;
    i_ex_valid       = 1'b0;
    i_ex_mem_read    = 1'b0;
    i_ex_rd_addr     = 5'd0;
    i_ex_redirect    = 1'b0;
    i_mem_valid      = 1'b0;
    i_mem_access     = 1'b0;
    i_dmem_ready     = 1'b0;
    i_wb_retire_halt = 1'b0;
  endtask

  initial begin
    // ---- reset ----
    i_rst = 1'b1;
    idle_inputs();
    tick();
    check("rst_ctl", 32'(ctl), 32'(CTL_RST));
    check("rst_stall_cnt", 32'(o_stall_cycles), 32'd0);
    check("rst_flush_cnt", 32'(o_flush_count), 32'd0);
    i_rst = 1'b0;
    settle();
    check("idle_ctl", 32'(ctl), 32'(CTL_IDLE));

    // ---- load-use on rs1: lw x5 in EX, add reading x5 in ID ----
    tick();
    i_ex_valid = 1'b1; i_ex_mem_read = 1'b1; i_ex_rd_addr = 5'd5;
    i_id_rs1_addr = 5'd5; i_id_rs1_used = 1'b1;
    settle();
    check("lu_ctl", 32'(ctl), 32'(CTL_LU));
    tick();
    // load now in MEM with a zero-wait access; EX holds the bubble
    idle_inputs();
    i_mem_valid = 1'b1; i_mem_access = 1'b1; i_dmem_ready = 1'b1;
    settle();
    check("lu_clear_ctl", 32'(ctl), 32'(CTL_REQ));
    check("lu_stall_cnt", 32'(o_stall_cycles), 32'd1);
    tick();

    // ---- load to x0: no hazard ----
    idle_inputs();
    i_ex_valid = 1'b1; i_ex_mem_read = 1'b1; i_ex_rd_addr = 5'd0;
    i_id_rs1_addr = 5'd0; i_id_rs1_used = 1'b1;
    settle();
    check("x0_ctl", 32'(ctl), 32'(CTL_IDLE));
    tick();
    check("x0_stall_cnt", 32'(o_stall_cycles), 32'd1);

    // ---- matching rs1 that is not read: no hazard ----
    i_ex_rd_addr = 5'd9; i_id_rs1_addr = 5'd9; i_id_rs1_used = 1'b0;
    settle();
    check("unused_rs1_ctl", 32'(ctl), 32'(CTL_IDLE));
    tick();

    // ---- load-use on rs2 ----
    i_ex_rd_addr = 5'd7; i_id_rs2_addr = 5'd7; i_id_rs2_used = 1'b1;
    settle();
    check("lu_rs2_ctl", 32'(ctl), 32'(CTL_LU));
    tick();
    check("lu_rs2_stall_cnt", 32'(o_stall_cycles), 32'd2);

    // ---- memory wait: 3 not-ready cycles then ready ----
    idle_inputs();
    i_mem_valid = 1'b1; i_mem_access = 1'b1; i_dmem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      check($sformatf("mw_stall_%0d", c), 32'(ctl), 32'(CTL_MSTALL));
      tick();
    end
    i_dmem_ready = 1'b1;
    settle();
    check("mw_ready_ctl", 32'(ctl), 32'(CTL_REQ));
    tick();
    idle_inputs();
    settle();
    check("mw_back_run_ctl", 32'(ctl), 32'(CTL_IDLE));
    check("mw_stall_cnt", 32'(o_stall_cycles), 32'd5);

    // ---- redirect with simultaneous load-use ----
    i_ex_valid = 1'b1; i_ex_mem_read = 1'b1; i_ex_rd_addr = 5'd5;
    i_id_rs1_addr = 5'd5; i_id_rs1_used = 1'b1; i_ex_redirect = 1'b1;
    settle();
    check("redir_lu_ctl", 32'(ctl), 32'(CTL_REDIR));
    tick();
    check("redir_flush_cnt", 32'(o_flush_count), 32'd1);
    check("redir_stall_cnt", 32'(o_stall_cycles), 32'd5);

    // ---- redirect held in EX during a memory wait ----
    idle_inputs();
    i_ex_valid = 1'b1; i_ex_redirect = 1'b1;
    i_mem_valid = 1'b1; i_mem_access = 1'b1; i_dmem_ready = 1'b0;
    settle();
    check("rmw_run_ctl", 32'(ctl), 32'(CTL_MSTALL));
    tick();
    settle();
    check("rmw_wait_ctl", 32'(ctl), 32'(CTL_MSTALL));
    tick();
    i_dmem_ready = 1'b1;
    settle();
    check("rmw_ready_ctl", 32'(ctl), 32'(CTL_REQ));
    tick();
    check("rmw_flush_cnt_pre", 32'(o_flush_count), 32'd1);
    i_mem_valid = 1'b0; i_mem_access = 1'b0; i_dmem_ready = 1'b0;
    settle();
    check("rmw_flush_ctl", 32'(ctl), 32'(CTL_REDIR));
    tick();
    check("rmw_flush_cnt", 32'(o_flush_count), 32'd2);
    check("rmw_stall_cnt", 32'(o_stall_cycles), 32'd7);

    // ---- halt retires mid memory wait ----
    idle_inputs();
    i_mem_valid = 1'b1; i_mem_access = 1'b1; i_dmem_ready = 1'b0;
    tick();
    settle();
    check("halt_wait_ctl", 32'(ctl), 32'(CTL_MSTALL));
    i_wb_retire_halt = 1'b1;
    tick();
    i_wb_retire_halt = 1'b0;
    settle();
    check("halted_ctl", 32'(ctl), 32'(CTL_HALT));
    check("halt_stall_cnt", 32'(o_stall_cycles), 32'd9);
    // activity while halted changes nothing
    i_dmem_ready = 1'b1; i_ex_valid = 1'b1; i_ex_redirect = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    check("halted_hold_ctl", 32'(ctl), 32'(CTL_HALT));
    check("halted_stall_cnt", 32'(o_stall_cycles), 32'd9);
    check("halted_flush_cnt", 32'(o_flush_count), 32'd2);

    // ---- one-cycle reset exits HALTED ----
    idle_inputs();
    i_rst = 1'b1;
    settle();
    check("rst_in_halt_ctl", 32'(ctl), 32'(CTL_RST_H));
    tick();
    i_rst = 1'b0;
    settle();
    check("post_rst_ctl", 32'(ctl), 32'(CTL_IDLE));
    check("post_rst_stall_cnt", 32'(o_stall_cycles), 32'd0);
    check("post_rst_flush_cnt", 32'(o_flush_count), 32'd0);

    // ---- stall counter saturation: 20 wait cycles into a 4-bit counter ----
    i_mem_valid = 1'b1; i_mem_access = 1'b1; i_dmem_ready = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    check("sat_stall_cnt", 32'(o_stall_cycles), 32'd15);
    i_dmem_ready = 1'b1;
    tick();
    check("sat_hold_cnt", 32'(o_stall_cycles), 32'd15);

    // ---- flush counter saturation: 20 back-to-back redirects ----
    idle_inputs();
    i_ex_valid = 1'b1; i_ex_redirect = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    check("sat_flush_cnt", 32'(o_flush_count), 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pipe_hazard_ctrl

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the five-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Produces per-register stall (hold) and flush/bubble controls from four sources: load-use hazards, EX-stage redirects, a multi-cycle data-memory handshake and halt retirement.
- Sits beside the datapath in the core top level. It observes decoded ID/EX/MEM/WB fields and drives enables of the stage registers and the PC.
- Also keeps saturating stall/flush performance counters.

Parameters:
- CNT_W, 32, width of each performance counter.

Ports:
- i_clk  in  1  core clock
- i_rst  in  1  synchronous, active-high reset
- i_id_rs1_addr  in  5  rs1 of instruction in ID
- i_id_rs2_addr  in  5  rs2 of instruction in ID
- i_id_rs1_used  in  1  ID instruction reads rs1
- i_id_rs2_used  in  1  ID instruction reads rs2
- i_ex_valid  in  1  ID/EX holds a valid instruction
- i_ex_mem_read  in  1  EX instruction is a load
- i_ex_rd_addr  in  5  EX destination register
- i_ex_redirect  in  1  EX resolved taken branch/jump (PC must change)
- i_mem_valid  in  1  EX/MEM holds a valid instruction
- i_mem_access  in  1  EX/MEM instruction is load or store
- i_dmem_ready  in  1  data memory completes the access this cycle
- i_wb_retire_halt  in  1  halt instruction retiring in WB
- o_pc_stall  out  1  hold PC
- o_if_id_stall  out  1  hold IF/ID
- o_if_id_flush  out  1  load NOP/invalid into IF/ID
- o_id_ex_stall  out  1  hold ID/EX
- o_id_ex_flush  out  1  load bubble into ID/EX
- o_ex_mem_stall  out  1  hold EX/MEM
- o_mem_wb_bubble  out  1  load bubble (valid=0, reg_write=0) into MEM/WB
- o_dmem_req  out  1  data memory request strobe
- o_halted  out  1  core halted
- o_stall_cycles  out  CNT_W  cycles with any stall asserted
- o_flush_count  out  CNT_W  redirect events taken

Behaviour:
- Clocking and reset:
  - Single clock i_clk. Reset i_rst is synchronous, active-high.
  - Reset puts state in RUN, clears both counters and clears o_halted.
  - While i_rst=1, combinational outputs are forced: all stalls 0, o_if_id_flush=o_id_ex_flush=o_mem_wb_bubble=1, o_dmem_req=0.
- States:
  - RUN: normal flow.
  - MEM_WAIT: outstanding data access.
  - HALTED: terminal state until reset.
- Derived terms:
  - load_use = i_ex_valid & i_ex_mem_read & (i_ex_rd_addr!=0) & ((i_id_rs1_used & rs1==rd) | (i_id_rs2_used & rs2==rd)).
  - mem_op = i_mem_valid & i_mem_access.
- o_dmem_req = mem_op in RUN, 1 in MEM_WAIT, 0 in HALTED.
- Priority per cycle: halt > memory wait > redirect > load-use.
- RUN:
  - mem_op & !i_dmem_ready: assert o_pc_stall, o_if_id_stall, o_id_ex_stall, o_ex_mem_stall and o_mem_wb_bubble. Next state MEM_WAIT.
  - mem_op & i_dmem_ready: zero-wait access, no stall.
  - i_ex_redirect & i_ex_valid (no memory stall): o_if_id_flush=o_id_ex_flush=1, no stalls. Redirect overrides a simultaneous load-use, because the dependent instruction is flushed.
  - load_use alone: o_pc_stall=o_if_id_stall=1, o_id_ex_flush=1 (one bubble). Clears the next cycle when the load reaches MEM.
- MEM_WAIT:
  - All four stalls plus o_mem_wb_bubble until i_dmem_ready=1.
  - On the ready cycle: no stalls, no bubble, and state returns to RUN.
  - A redirect pending in the frozen EX is evaluated normally in RUN afterwards. EX is held, so i_ex_redirect stays asserted.
- HALTED:
  - Entered the cycle after i_wb_retire_halt=1 from any state. This includes MEM_WAIT, where the access is abandoned and o_dmem_req drops.
  - In HALTED: o_halted=1 (registered), all four stalls=1, o_mem_wb_bubble=1, o_dmem_req=0.
  - Only i_rst exits HALTED.
- Counters:
  - o_stall_cycles increments by 1 on each non-reset cycle in which any of o_pc_stall/o_ex_mem_stall is 1 and state!=HALTED.
  - o_flush_count increments on each cycle in which the redirect flush is applied.
  - Both counters saturate at all-ones and never wrap.
- All control outputs except o_halted and the counters are combinational from state and inputs (zero latency).

Decomposition:
- Shared pipeline package holds:
  - state encoding (RUN=2'd0, MEM_WAIT=2'd1, HALTED=2'd2);
  - NOP encoding 32'h00000013;
  - the x0 register index constant.
- One natural sub-module: sat_counter (parameter CNT_W; inc, clear; saturating), instantiated twice.

Test Plan:
- Load-use: EX lw x5 (rd=5, mem_read=1); ID add reads rs1=5 -> one cycle with o_pc_stall=o_if_id_stall=o_id_ex_flush=1. Next cycle all 0. o_stall_cycles=1.
- Load to x0: rd=0, ID rs1=0 -> no stall, o_stall_cycles stays 0.
- Memory wait: mem_op=1, i_dmem_ready low for 3 cycles then high -> o_dmem_req high 4 cycles; all stalls plus bubble for 3 cycles; RUN on 4th. o_stall_cycles=3.
- Redirect with simultaneous load-use -> o_if_id_flush=o_id_ex_flush=1, o_pc_stall=0, o_flush_count=1.
- Redirect during MEM_WAIT: ready after 2 cycles -> flush applied only on the first RUN cycle after ready.
- Halt retires mid MEM_WAIT -> next cycle o_halted=1, o_dmem_req=0, all stalls 1 indefinitely. i_rst=1 for 1 cycle -> o_halted=0, counters 0, state RUN.
